// File: rtl/cache_mem_arbiter.sv
// Cacheline arbiter between the I-cache and D-cache and a single beat-wide
// physical memory port. Grants one requester at a time, alternating under
// contention, and splits or assembles each line as a burst of BEATS beats.
module cache_mem_arbiter #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64,
  parameter int BEATS  = LINE_W / BEAT_W,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [BEAT_W-1:0] pmem_wdata,
  input  logic [BEAT_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam int CNT_W = $clog2(BEATS);
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_e;
  typedef logic [BEATS-1:0][BEAT_W-1:0] line_t;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic              side_q, side_d;          // 1 = D-cache owns the burst
  logic              lastGrant_q, lastGrant_d; // 1 = D-cache was granted last
  logic [ADDR_W-1:0] addr_q, addr_d;
  line_t             wLine_q, wLine_d;
  line_t             rBuf_q, rBuf_d;
  line_t             iRdata_q, iRdata_d;
  line_t             dRdata_q, dRdata_d;
  logic              pmemRead_q, pmemRead_d;
  logic              pmemWrite_q, pmemWrite_d;

  logic              iReq;
  logic              dReq;
  logic              grantD;
  logic [ADDR_W-1:0] reqAddr;
  logic [ADDR_W-1:0] alignedAddr;

  // Under contention the side that did not win last time gets the port.
  assign iReq        = i_read;
  assign dReq        = d_read | d_write;
  assign grantD      = dReq & (~iReq | ~lastGrant_q);
  assign reqAddr     = grantD ? d_address : i_address;
  assign alignedAddr = {reqAddr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  assign pmem_read    = pmemRead_q;
  assign pmem_write   = pmemWrite_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wLine_q[beat_q];
  assign i_rdata      = iRdata_q;
  assign d_rdata      = dRdata_q;
  assign i_resp       = (state_q == DONE) & ~side_q;
  assign d_resp       = (state_q == DONE) & side_q;

  // State register; reset abandons any burst and clears all line storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      side_q      <= 1'b0;
      lastGrant_q <= 1'b0;
      addr_q      <= '0;
      wLine_q     <= '0;
      rBuf_q      <= '0;
      iRdata_q    <= '0;
      dRdata_q    <= '0;
      pmemRead_q  <= 1'b0;
      pmemWrite_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      side_q      <= side_d;
      lastGrant_q <= lastGrant_d;
      addr_q      <= addr_d;
      wLine_q     <= wLine_d;
      rBuf_q      <= rBuf_d;
      iRdata_q    <= iRdata_d;
      dRdata_q    <= dRdata_d;
      pmemRead_q  <= pmemRead_d;
      pmemWrite_q <= pmemWrite_d;
    end
  end

  // Next-state logic: grant in IDLE, count beats in the bursts, one-cycle DONE.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    side_d      = side_q;
    lastGrant_d = lastGrant_q;
    addr_d      = addr_q;
    wLine_d     = wLine_q;
    rBuf_d      = rBuf_q;
    iRdata_d    = iRdata_q;
    dRdata_d    = dRdata_q;
    pmemRead_d  = pmemRead_q;
    pmemWrite_d = pmemWrite_q;

    unique case (state_q)
      IDLE: begin
        if (iReq || dReq) begin
          side_d      = grantD;
          lastGrant_d = grantD;
          addr_d      = alignedAddr;
          beat_d      = '0;
          if (grantD && d_write) begin
            wLine_d     = d_wdata;
            pmemWrite_d = 1'b1;
            state_d     = WR_BURST;
          end else begin
            pmemRead_d = 1'b1;
            state_d    = RD_BURST;
          end
        end
      end
      RD_BURST: begin
        if (pmem_resp) begin
          rBuf_d[beat_q] = pmem_rdata;
          if (beat_q == LAST_BEAT) begin
            state_d    = DONE;
            pmemRead_d = 1'b0;
            beat_d     = '0;
            if (side_q) begin
              dRdata_d = rBuf_d;
            end else begin
              iRdata_d = rBuf_d;
            end
          end else begin
            beat_d = beat_q + CNT_W'(1);
          end
        end
      end
      WR_BURST: begin
        if (pmem_resp) begin
          if (beat_q == LAST_BEAT) begin
            state_d     = DONE;
            pmemWrite_d = 1'b0;
            beat_d      = '0;
          end else begin
            beat_d = beat_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        beat_d  = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter. Expected responses are queued
// when a request is issued and popped when the DUT signals completion.
module tb_cache_mem_arbiter;

  localparam int LINE_W = 256;
  localparam int BEAT_W = 64;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [BEAT_W-1:0] pmem_wdata;
  logic [BEAT_W-1:0] pmem_rdata;
  logic              pmem_resp;

  typedef struct {
    bit                isD;
    logic [LINE_W-1:0] rdata;
  } exp_t;

  exp_t              sb[$];
  logic [LINE_W-1:0] lastD;
  int                checks = 0;
  int                passes = 0;
  int                cyc = 0;

  cache_mem_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LINE_W-1:0] mkLine(input logic [15:0] tag);
    logic [LINE_W-1:0] l;
    for (int k = 0; k < 4; k++) begin
      l[64*k +: 64] = {tag, 16'(k), ~tag, 16'(k + 8)};
    end
    return l;
  endfunction

  // Plays the memory side of one burst: gaps[k] idle cycles before beat k.
  // Checks the port every cycle, then pops the scoreboard in the DONE cycle.
  task automatic serveBurst(input logic [LINE_W-1:0] line, input int g0, input int g1,
                            input int g2, input int g3, input logic [ADDR_W-1:0] expAddr);
    int   gaps[4];
    int   n;
    bit   isWr;
    bit   ctlOk;
    exp_t e;
    logic [LINE_W-1:0] got;
    gaps[0] = g0; gaps[1] = g1; gaps[2] = g2; gaps[3] = g3;
    n = 0;
    while (!(pmem_read === 1'b1 || pmem_write === 1'b1) && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 20) begin
      $display("[TB] FAIL burst_start pmem_read=%b pmem_write=%b after 20 cycles, need one high", pmem_read, pmem_write);
      return;
    end
    passes++;
    isWr = pmem_write;
    for (int k = 0; k < 4; k++) begin
      for (int w = 0; w <= gaps[k]; w++) begin
        pmem_resp  = (w == gaps[k]);
        pmem_rdata = (w == gaps[k]) ? line[64*k +: 64] : 64'hBAD0_BAD0_BAD0_BAD0;
        ctlOk = isWr ? (pmem_write === 1'b1 && pmem_read === 1'b0)
                     : (pmem_read === 1'b1 && pmem_write === 1'b0);
        checks++;
        if (!ctlOk || pmem_address !== expAddr || (isWr && pmem_wdata !== line[64*k +: 64]))
          $display("[TB] FAIL beat%0d_port rd=%b wr=%b addr=%h need %h wdata=%h need %h", k,
                   pmem_read, pmem_write, pmem_address, expAddr, pmem_wdata,
                   isWr ? line[64*k +: 64] : pmem_wdata);
        else
          passes++;
        tick();
      end
    end
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    checks++;
    if (sb.size() == 0) begin
      $display("[TB] FAIL scoreboard_empty i_resp=%b d_resp=%b with no expected entry", i_resp, d_resp);
    end else begin
      e   = sb.pop_front();
      got = e.isD ? d_rdata : i_rdata;
      if (i_resp !== !e.isD || d_resp !== e.isD)
        $display("[TB] FAIL resp_side i_resp=%b d_resp=%b need i_resp=%b d_resp=%b", i_resp, d_resp, !e.isD, e.isD);
      else if (got !== e.rdata)
        $display("[TB] FAIL line_%s got=%h need=%h", e.isD ? "d" : "i", got, e.rdata);
      else
        passes++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    i_read = 1'b0; i_address = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;
    lastD = '0;
    repeat (2) tick();
    checks++;
    if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0)
      $display("[TB] FAIL reset_ctl rd/wr/iresp/dresp=%b need 0000", {pmem_read, pmem_write, i_resp, d_resp});
    else passes++;
    checks++;
    if (pmem_address !== '0 || pmem_wdata !== '0)
      $display("[TB] FAIL reset_port addr=%h wdata=%h need 0", pmem_address, pmem_wdata);
    else passes++;
    checks++;
    if (i_rdata !== '0 || d_rdata !== '0)
      $display("[TB] FAIL reset_rdata i=%h d=%h need 0", i_rdata, d_rdata);
    else passes++;
    rst = 1'b1;
    tick();
    checks++;
    if (pmem_read !== 1'b0 || pmem_write !== 1'b0)
      $display("[TB] FAIL idle_after_reset rd=%b wr=%b need 0", pmem_read, pmem_write);
    else passes++;
  endtask

  task automatic test_contention();
    logic [LINE_W-1:0] ld1, li1, ld2, li2;
    ld1 = mkLine(16'hD001); li1 = mkLine(16'h1001);
    ld2 = mkLine(16'hD002); li2 = mkLine(16'h1002);
    sb.push_back('{1'b1, ld1});
    sb.push_back('{1'b0, li1});
    sb.push_back('{1'b1, ld2});
    sb.push_back('{1'b0, li2});
    i_address = 32'h0000_0100; d_address = 32'h0000_0200;
    i_read = 1'b1; d_read = 1'b1;
    serveBurst(ld1, 0, 0, 0, 0, 32'h0000_0200);
    serveBurst(li1, 0, 0, 0, 0, 32'h0000_0100);
    serveBurst(ld2, 0, 0, 0, 0, 32'h0000_0200);
    serveBurst(li2, 0, 0, 0, 0, 32'h0000_0100);
    i_read = 1'b0; d_read = 1'b0;
    lastD = ld2;
    tick();
  endtask

  task automatic test_i_read();
    logic [LINE_W-1:0] line;
    int reqCyc;
    line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    sb.push_back('{1'b0, line});
    i_address = 32'h0000_1234;
    i_read = 1'b1;
    reqCyc = cyc;
    tick();
    i_address = 32'hFFFF_FFE0;
    serveBurst(line, 0, 0, 0, 0, 32'h0000_1220);
    checks++;
    if (cyc - reqCyc != 5 || i_resp !== 1'b1)
      $display("[TB] FAIL i_latency cycles=%0d i_resp=%b need 5 and 1", cyc - reqCyc, i_resp);
    else passes++;
    i_read = 1'b0;
    tick();
    checks++;
    if (i_resp !== 1'b0 || i_rdata !== line)
      $display("[TB] FAIL i_pulse_hold i_resp=%b i_rdata=%h need 0 and %h", i_resp, i_rdata, line);
    else passes++;
  endtask

  task automatic test_d_write();
    logic [LINE_W-1:0] line;
    int reqCyc;
    line = {64'hDDDD, 64'hCCCC, 64'hBBBB, 64'hAAAA};
    sb.push_back('{1'b1, lastD});
    d_address = 32'h8000_0040;
    d_wdata = line;
    d_write = 1'b1;
    reqCyc = cyc;
    serveBurst(line, 1, 2, 0, 2, 32'h8000_0040);
    checks++;
    if (cyc - reqCyc != 10 || d_resp !== 1'b1)
      $display("[TB] FAIL d_write_latency cycles=%0d d_resp=%b need 10 and 1", cyc - reqCyc, d_resp);
    else passes++;
    d_write = 1'b0;
    tick();
    checks++;
    if (d_resp !== 1'b0)
      $display("[TB] FAIL d_write_pulse d_resp=%b need 0", d_resp);
    else passes++;
  endtask

  task automatic test_both_high();
    logic [LINE_W-1:0] line;
    line = mkLine(16'hB0B0);
    sb.push_back('{1'b1, lastD});
    d_address = 32'h4000_001F;
    d_wdata = line;
    d_read = 1'b1; d_write = 1'b1;
    tick();
    checks++;
    if (pmem_write !== 1'b1 || pmem_read !== 1'b0)
      $display("[TB] FAIL both_high_kind pmem_write=%b pmem_read=%b need 1 and 0", pmem_write, pmem_read);
    else passes++;
    serveBurst(line, 0, 1, 0, 0, 32'h4000_0000);
    d_read = 1'b0; d_write = 1'b0;
    tick();
  endtask

  task automatic test_spurious();
    logic [LINE_W-1:0] line;
    line = mkLine(16'hA1A1);
    repeat (2) tick();
    pmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    pmem_resp = 1'b1;
    repeat (2) tick();
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    tick();
    sb.push_back('{1'b0, line});
    i_address = 32'h0000_3000;
    i_read = 1'b1;
    serveBurst(line, 0, 0, 0, 0, 32'h0000_3000);
    checks++;
    if (i_resp !== 1'b1)
      $display("[TB] FAIL spurious_i_resp i_resp=%b need 1", i_resp);
    else passes++;
    i_read = 1'b0;
    tick();
  endtask

  task automatic test_reset_midburst();
    logic [LINE_W-1:0] line;
    int n;
    i_address = 32'h0000_2000;
    i_read = 1'b1;
    n = 0;
    while (pmem_read !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 20) $display("[TB] FAIL midburst_start pmem_read=%b need 1", pmem_read);
    else passes++;
    pmem_rdata = 64'h0101_0101_0101_0101; pmem_resp = 1'b1;
    tick();
    pmem_rdata = 64'h0202_0202_0202_0202;
    tick();
    pmem_resp = 1'b0; pmem_rdata = '0;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0 || pmem_address !== '0 || pmem_wdata !== '0)
      $display("[TB] FAIL async_reset_port ctl=%b addr=%h wdata=%h need all 0",
               {pmem_read, pmem_write, i_resp, d_resp}, pmem_address, pmem_wdata);
    else passes++;
    checks++;
    if (i_rdata !== '0 || d_rdata !== '0)
      $display("[TB] FAIL async_reset_rdata i=%h d=%h need 0", i_rdata, d_rdata);
    else passes++;
    i_read = 1'b0;
    lastD = '0;
    repeat (3) begin
      tick();
      checks++;
      if (i_resp !== 1'b0 || d_resp !== 1'b0)
        $display("[TB] FAIL reset_hold_resp i_resp=%b d_resp=%b need 0", i_resp, d_resp);
      else passes++;
    end
    rst = 1'b1;
    tick();
    checks++;
    if (i_resp !== 1'b0 || pmem_read !== 1'b0)
      $display("[TB] FAIL after_reset_idle i_resp=%b pmem_read=%b need 0", i_resp, pmem_read);
    else passes++;
    line = mkLine(16'h5A5A);
    sb.push_back('{1'b0, line});
    i_read = 1'b1;
    serveBurst(line, 0, 0, 0, 0, 32'h0000_2000);
    i_read = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_contention();
    test_i_read();
    test_d_write();
    test_both_high();
    test_spurious();
    test_reset_midburst();
    repeat (3) tick();
    checks++;
    if (sb.size() != 0)
      $display("[TB] FAIL scoreboard_drain left=%0d need 0", sb.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Sits directly downstream of the pipeline's instruction and data memory ports, behind the I-cache and D-cache, once the magic-memory interface is retired.
- Arbitrates 256-bit cacheline requests from the I-cache (read-only) and the D-cache (read/write) onto the single physical memory port.
- That port carries 64-bit beats, 4 beats per line.
- Owns the burst sequencing, the line assembly/disassembly, and fairness between the two requesters.

Parameters:
- LINE_W, 256, cacheline width in bits.
- BEAT_W, 64, pmem data width per beat.
- BEATS, LINE_W/BEAT_W (=4), beats per line; must be a power of two ≥ 2.
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_read  in  1  I-cache line read request; held until i_resp.
- i_address  in  ADDR_W  I-cache line address.
- i_rdata  out  LINE_W  assembled line for the I-cache.
- i_resp  out  1  I-cache completion pulse.
- d_read  in  1  D-cache line read request; held until d_resp.
- d_write  in  1  D-cache line write-back request; held until d_resp.
- d_address  in  ADDR_W  D-cache line address.
- d_wdata  in  LINE_W  D-cache write-back line.
- d_rdata  out  LINE_W  assembled line for the D-cache.
- d_resp  out  1  D-cache completion pulse.
- pmem_read  out  1  burst read to physical memory.
- pmem_write  out  1  burst write to physical memory.
- pmem_address  out  ADDR_W  line-aligned burst address.
- pmem_wdata  out  BEAT_W  current write beat.
- pmem_rdata  in  BEAT_W  current read beat.
- pmem_resp  in  1  one pulse per beat transferred.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE and beat counter to 0.
  - pmem_read, pmem_write, i_resp and d_resp go to 0.
  - pmem_address, pmem_wdata, i_rdata and d_rdata go to 0.
  - last_grant goes to I, so D wins the first contention.
- A reset mid-burst abandons the burst. No resp is issued and the line buffer is cleared.
- States: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE, sampling requests:
  - Contention rule: if both sides request, grant the side opposite last_grant. Otherwise grant whichever side requests.
  - Grant with d_read and d_write both high: treat as a write.
  - On grant: latch the side, latch the address with its low log2(LINE_W/8) bits forced to 0, and latch d_wdata for writes. Update last_grant. Go to RD_BURST or WR_BURST.
  - pmem_read/pmem_write are registered. They assert starting the cycle after the grant.
- RD_BURST:
  - pmem_read=1 and pmem_address is held constant.
  - On each pmem_resp, store pmem_rdata into line bits [BEAT_W*k +: BEAT_W] (k = beat counter), then increment k.
  - On the pmem_resp where k=BEATS-1, go to DONE; pmem_read drops the next cycle.
- WR_BURST:
  - pmem_write=1 and pmem_wdata = latched line [BEAT_W*k +: BEAT_W].
  - k advances on pmem_resp, so pmem_wdata changes only after a resp.
  - On the final resp, go to DONE.
- DONE:
  - Exactly one cycle. The granted side's resp is 1 for this cycle only.
  - For a read, the granted side's rdata holds the full line from this cycle. It stays stable until that side's next read completes.
  - For a D write, d_rdata is unchanged.
  - k returns to 0 and the state returns to IDLE.
  - Requests seen in DONE are ignored; a requester still holding a request in the following IDLE cycle is treated as a new request.
- pmem_resp seen in IDLE or DONE is ignored.
- Latency with zero-wait pmem (resp every cycle): grant at cycle 0, beats at cycles 1–4, resp at cycle 5.
- The non-granted requester is never starved: strict alternation under continuous contention.
- A requester changing its address while pending has no effect after the grant (the address is latched).

Test Plan:
- Single I read, addr 0x0000_1234, pmem returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 with resp every cycle:
  - Required: pmem_address = 0x0000_1220 throughout.
  - Required: i_resp is a single-cycle pulse 5 cycles after the request.
  - Required: i_rdata = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- D write, addr 0x8000_0040, d_wdata = {64'hDDDD, 64'hCCCC, 64'hBBBB, 64'hAAAA}, pmem_resp on cycles 2, 5, 6, 9:
  - Required: pmem_wdata = AAAA, then BBBB, CCCC, DDDD, each changing only after a resp.
  - Required: d_resp pulses once, one cycle after the 4th resp.
- i_read and d_read asserted simultaneously out of reset, both held:
  - Required: D is served first, then I, then D again if re-requested.
  - Required: the grant order D, I, D, I under continuous contention.
- d_read and d_write both high:
  - Required: pmem_write is asserted and pmem_read stays 0.
- rst driven low after the 2nd beat of an I read, released 3 cycles later:
  - Required: all outputs are 0 asynchronously and no i_resp is issued.
  - Required: a re-issued i_read completes normally with a fresh 4 beats.
- Spurious pmem_resp in IDLE, then an I read:
  - Required: the beat counter is unaffected and the line is assembled from exactly the 4 in-burst beats.
